// File: rtl/axis_pha_pkg.sv
// Shared types and default widths for the pulse-height analysis front end.
// Holds the peak-detector state enum, the default stream/ADC/counter widths
// and the width of the dropped-peak status counter.
package axis_pha_pkg;

  localparam int unsigned DEF_AXIS_TDATA_WIDTH = 16;
  localparam int unsigned DEF_ADC_DATA_WIDTH   = 14;
  localparam int unsigned DEF_CNTR_WIDTH       = 16;
  localparam int unsigned DROP_CNT_WIDTH       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DEAD  = 2'd2
  } pha_state_e;

endpackage

// File: rtl/pha_bin_calc.sv
// Combinational bin-value computation for a detected peak.
//
// Macro: AXIS_PHA_BASELINE_EN
//   undefined: bin = peak in offset binary (sign bit inverted).
//   defined:   bin = peak - cfg_baseline, clamped to [0, 2^ADC_DATA_WIDTH - 1].
//
// Ports:
//   peak          in   signed peak sample
//   cfg_baseline  in   signed baseline (only with AXIS_PHA_BASELINE_EN)
//   bin           out  unsigned bin value
module pha_bin_calc #(
  parameter int unsigned ADC_DATA_WIDTH = 14
) (
  input  logic signed [ADC_DATA_WIDTH-1:0] peak,
`ifdef AXIS_PHA_BASELINE_EN
  input  logic signed [ADC_DATA_WIDTH-1:0] cfg_baseline,
`endif
  output logic        [ADC_DATA_WIDTH-1:0] bin
);

`ifdef AXIS_PHA_BASELINE_EN
  logic [ADC_DATA_WIDTH:0] diff;

  always_comb begin
    // Sign-extend both operands by one bit so the difference cannot wrap.
    diff = {peak[ADC_DATA_WIDTH-1], peak} - {cfg_baseline[ADC_DATA_WIDTH-1], cfg_baseline};
    // The largest positive difference is 2^ADC_DATA_WIDTH - 1, so only the
    // negative side ever needs clamping.
    if (diff[ADC_DATA_WIDTH]) begin
      bin = '0;
    end else begin
      bin = diff[ADC_DATA_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    bin = {~peak[ADC_DATA_WIDTH-1], peak[ADC_DATA_WIDTH-2:0]};
  end
`endif

endmodule

// File: rtl/axis_peak_detector.sv
// Pulse-height analysis front end. Scans a signed AXI4-Stream sample stream
// for local maxima, applies an amplitude window and a dead time, and emits one
// bin value per accepted peak through a one-deep output register. Peaks that
// arrive while the output word is blocked are dropped and counted.
//
// Macro: AXIS_PHA_BASELINE_EN adds cfg_baseline and baseline-relative bins.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   cfg_min/max     signed inclusive amplitude window
//   cfg_dead        dead time in accepted samples after each evaluated peak
//   cfg_baseline    signed baseline (only with AXIS_PHA_BASELINE_EN)
//   s_axis_*        sample input stream (never back-pressured after reset)
//   m_axis_*        bin value output stream
//   sts_drops       saturating count of dropped peaks
module axis_peak_detector
  import axis_pha_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = DEF_AXIS_TDATA_WIDTH,
  parameter int unsigned ADC_DATA_WIDTH   = DEF_ADC_DATA_WIDTH,
  parameter int unsigned CNTR_WIDTH       = DEF_CNTR_WIDTH
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic signed [ADC_DATA_WIDTH-1:0] cfg_min,
  input  logic signed [ADC_DATA_WIDTH-1:0] cfg_max,
  input  logic        [CNTR_WIDTH-1:0]     cfg_dead,
`ifdef AXIS_PHA_BASELINE_EN
  input  logic signed [ADC_DATA_WIDTH-1:0] cfg_baseline,
`endif
  output logic                             s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                             s_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]      m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic [DROP_CNT_WIDTH-1:0]        sts_drops
);

  pha_state_e                       state_q, state_d;
  logic signed [ADC_DATA_WIDTH-1:0] prev_q, prev_d;
  logic signed [ADC_DATA_WIDTH-1:0] peak_q, peak_d;
  logic        [CNTR_WIDTH-1:0]     cnt_q, cnt_d;
  logic                             tready_q;
  logic                             tvalid_q, tvalid_d;
  logic [AXIS_TDATA_WIDTH-1:0]      tdata_q, tdata_d;
  logic [DROP_CNT_WIDTH-1:0]        drops_q, drops_d;

  logic signed [ADC_DATA_WIDTH-1:0] x;
  logic                             fire;
  logic                             evaluate;
  logic                             in_window;
  logic [ADC_DATA_WIDTH-1:0]        bin;

  assign x    = s_axis_tdata[ADC_DATA_WIDTH-1:0];
  assign fire = s_axis_tvalid & tready_q;

  if (AXIS_TDATA_WIDTH > ADC_DATA_WIDTH) begin : g_tdata_hi
    logic unused_tdata_hi;
    assign unused_tdata_hi = ^s_axis_tdata[AXIS_TDATA_WIDTH-1:ADC_DATA_WIDTH];
  end

  pha_bin_calc #(
    .ADC_DATA_WIDTH(ADC_DATA_WIDTH)
  ) u_bin_calc (
    .peak        (peak_q),
`ifdef AXIS_PHA_BASELINE_EN
    .cfg_baseline(cfg_baseline),
`endif
    .bin         (bin)
  );

  // An empty window (cfg_min > cfg_max) falls out naturally: no peak satisfies both.
  assign in_window = (cfg_min <= peak_q) && (peak_q <= cfg_max);

  // Peak-tracking FSM.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    peak_d   = peak_q;
    cnt_d    = cnt_q;
    evaluate = 1'b0;
    if (fire) begin
      prev_d = x;
      case (state_q)
        IDLE: begin
          if (x > prev_q) begin
            peak_d  = x;
            state_d = TRACK;
          end
        end
        TRACK: begin
          // A flat top keeps tracking so the emitted peak is the last sample before the fall.
          if (x >= prev_q) begin
            peak_d = x;
          end else begin
            evaluate = 1'b1;
            if (cfg_dead == '0) begin
              state_d = IDLE;
            end else begin
              cnt_d   = cfg_dead;
              state_d = DEAD;
            end
          end
        end
        DEAD: begin
          cnt_d = cnt_q - CNTR_WIDTH'(1);
          // Leave on the sample that brings the counter down to 1.
          if (cnt_q <= CNTR_WIDTH'(2)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // One-deep output register with drop accounting.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    drops_d  = drops_q;
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end
    if (evaluate && in_window) begin
      if (tvalid_q && !m_axis_tready) begin
        if (drops_q != '1) begin
          drops_d = drops_q + DROP_CNT_WIDTH'(1);
        end
      end else begin
        tdata_d  = AXIS_TDATA_WIDTH'(bin);
        tvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      peak_q   <= '0;
      cnt_q    <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      drops_q  <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      peak_q   <= peak_d;
      cnt_q    <= cnt_d;
      tready_q <= 1'b1;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      drops_q  <= drops_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign sts_drops     = drops_q;

endmodule

// File: tb/tb_axis_peak_detector.sv
// Directed bench for axis_peak_detector. Each step drives one sample, waits
// for the processing edge and looks at the outputs 1 time unit later.
module tb_axis_peak_detector;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic signed [13:0] cfg_min;
  logic signed [13:0] cfg_max;
  logic        [15:0] cfg_dead;
  logic               s_axis_tready;
  logic        [15:0] s_axis_tdata;
  logic               s_axis_tvalid;
  logic               m_axis_tready;
  logic        [15:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic        [31:0] sts_drops;
  int                 base_val = 0;
`ifdef AXIS_PHA_BASELINE_EN
  logic signed [13:0] cfg_baseline;
  assign cfg_baseline = 14'(base_val);
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_peak_detector #(
    .AXIS_TDATA_WIDTH(16),
    .ADC_DATA_WIDTH  (14),
    .CNTR_WIDTH      (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_min      (cfg_min),
    .cfg_max      (cfg_max),
    .cfg_dead     (cfg_dead),
`ifdef AXIS_PHA_BASELINE_EN
    .cfg_baseline (cfg_baseline),
`endif
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .sts_drops    (sts_drops)
  );

  // Expected bin for a peak: offset binary, or baseline-relative with clamp.
  function automatic logic [15:0] exp_bin(input int p);
`ifdef AXIS_PHA_BASELINE_EN
    int d;
    d = p - base_val;
    if (d < 0) d = 0;
    if (d > 16383) d = 16383;
    return 16'(d);
`else
    return 16'(p + 8192);
`endif
  endfunction

  task automatic step(input int x);
    s_axis_tdata = x[15:0];
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'd123;
    m_axis_tready = 1'b1;
    cfg_min       = 14'sd50;
    cfg_max       = 14'sd1000;
    cfg_dead      = 16'd0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL reset_tready: got %b want 0", s_axis_tready);
    end
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid);
    end
    checks++;
    if (m_axis_tdata !== 16'd0) begin
      errors++; $display("FAIL reset_tdata: got %0d want 0", m_axis_tdata);
    end
    checks++;
    if (sts_drops !== 32'd0) begin
      errors++; $display("FAIL reset_drops: got %0d want 0", sts_drops);
    end
    s_axis_tdata = 16'd0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL release_tready: got %b want 1", s_axis_tready);
    end
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL release_tvalid: got %b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_single_peak;
    int s [5];
    bit v [5];
    s = '{0, 100, 300, 200, 0};
    v = '{0, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      step(s[i]);
      checks++;
      if (m_axis_tvalid !== v[i]) begin
        errors++; $display("FAIL single_valid[%0d]: got %b want %b", i, m_axis_tvalid, v[i]);
      end
      if (v[i]) begin
        checks++;
        if (m_axis_tdata !== exp_bin(300)) begin
          errors++;
          $display("FAIL single_word: got %0d want %0d", m_axis_tdata, exp_bin(300));
        end
      end
    end
  endtask

  task automatic test_window;
    int s [6];
    bit v [6];
    int p [6];
    // Upper bound one below the peak: nothing emitted, nothing dropped.
    cfg_max = 14'sd299;
    s = '{0, 100, 300, 200, 0, 0};
    for (int i = 0; i < 5; i++) begin
      step(s[i]);
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
        errors++; $display("FAIL window_reject[%0d]: got %b want 0", i, m_axis_tvalid);
      end
    end
    checks++;
    if (sts_drops !== 32'd0) begin
      errors++; $display("FAIL window_drops: got %0d want 0", sts_drops);
    end
    // Full range. -8192 can never be a peak (nothing rises to it), so the
    // lowest detectable peak -8191 is used, then the top code 8191.
    cfg_min = 14'(-8192);
    cfg_max = 14'sd8191;
    s = '{-8192, -8191, -8192, 8191, 8190, 0};
    v = '{0, 0, 1, 0, 1, 0};
    p = '{0, 0, -8191, 0, 8191, 0};
    for (int i = 0; i < 6; i++) begin
      step(s[i]);
      checks++;
      if (m_axis_tvalid !== v[i]) begin
        errors++; $display("FAIL extreme_valid[%0d]: got %b want %b", i, m_axis_tvalid, v[i]);
      end
      if (v[i]) begin
        checks++;
        if (m_axis_tdata !== exp_bin(p[i])) begin
          errors++;
          $display("FAIL extreme_word[%0d]: got %0d want %0d", i, m_axis_tdata, exp_bin(p[i]));
        end
      end
    end
    // Degenerate window exactly at the peak is inclusive on both sides.
    cfg_min = 14'sd300;
    cfg_max = 14'sd300;
    step(300);
    step(0);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_bin(300)) begin
      errors++;
      $display("FAIL window_inclusive: valid=%b data=%0d want 1/%0d",
               m_axis_tvalid, m_axis_tdata, exp_bin(300));
    end
    // Inverted window: never emits.
    cfg_min = 14'sd301;
    step(300);
    step(0);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL window_inverted: got %b want 0", m_axis_tvalid);
    end
    cfg_min = 14'sd50;
    cfg_max = 14'sd1000;
  endtask

  task automatic test_dead_time;
    int s [9];
    bit v [9];
    int p [9];
    cfg_dead = 16'd3;
    s = '{0, 500, 0, 600, 0, 700, 0, 0, 0};
    v = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
    p = '{0, 0, 500, 0, 0, 0, 700, 0, 0};
    for (int i = 0; i < 9; i++) begin
      step(s[i]);
      checks++;
      if (m_axis_tvalid !== v[i]) begin
        errors++; $display("FAIL dead_valid[%0d]: got %b want %b", i, m_axis_tvalid, v[i]);
      end
      if (v[i]) begin
        checks++;
        if (m_axis_tdata !== exp_bin(p[i])) begin
          errors++;
          $display("FAIL dead_word[%0d]: got %0d want %0d", i, m_axis_tdata, exp_bin(p[i]));
        end
      end
    end
    cfg_dead = 16'd0;
  endtask

  task automatic test_back_to_back;
    int s [7];
    bit v [7];
    int p [7];
    s = '{100, 0, 200, 0, 300, 0, 0};
    v = '{0, 1, 0, 1, 0, 1, 0};
    p = '{0, 100, 0, 200, 0, 300, 0};
    for (int i = 0; i < 7; i++) begin
      step(s[i]);
      checks++;
      if (m_axis_tvalid !== v[i]) begin
        errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, m_axis_tvalid, v[i]);
      end
      if (v[i]) begin
        checks++;
        if (m_axis_tdata !== exp_bin(p[i])) begin
          errors++;
          $display("FAIL b2b_word[%0d]: got %0d want %0d", i, m_axis_tdata, exp_bin(p[i]));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int s [7];
    bit v [7];
    m_axis_tready = 1'b0;
    s = '{300, 0, 400, 0, 500, 0, 600};
    v = '{0, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      step(s[i]);
      checks++;
      if (m_axis_tvalid !== v[i]) begin
        errors++; $display("FAIL bp_valid[%0d]: got %b want %b", i, m_axis_tvalid, v[i]);
      end
      if (v[i]) begin
        checks++;
        if (m_axis_tdata !== exp_bin(300)) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got %0d want %0d", i, m_axis_tdata, exp_bin(300));
        end
      end
    end
    checks++;
    if (sts_drops !== 32'd2) begin
      errors++; $display("FAIL bp_drops: got %0d want 2", sts_drops);
    end
    // Handshake coincides with the fourth emit: new word, tvalid stays high.
    m_axis_tready = 1'b1;
    step(0);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_bin(600)) begin
      errors++;
      $display("FAIL bp_reload: valid=%b data=%0d want 1/%0d",
               m_axis_tvalid, m_axis_tdata, exp_bin(600));
    end
    checks++;
    if (sts_drops !== 32'd2) begin
      errors++; $display("FAIL bp_reload_drops: got %0d want 2", sts_drops);
    end
    m_axis_tready = 1'b0;
    step(0);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_bin(600)) begin
      errors++;
      $display("FAIL bp_hold2: valid=%b data=%0d want 1/%0d",
               m_axis_tvalid, m_axis_tdata, exp_bin(600));
    end
    m_axis_tready = 1'b1;
    step(0);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got %b want 0", m_axis_tvalid);
    end
  endtask

`ifdef AXIS_PHA_BASELINE_EN
  task automatic test_baseline;
    base_val = 200;
    step(300);
    step(0);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd100) begin
      errors++;
      $display("FAIL baseline_sub: valid=%b data=%0d want 1/100", m_axis_tvalid, m_axis_tdata);
    end
    base_val = 400;
    step(300);
    step(0);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd0) begin
      errors++;
      $display("FAIL baseline_clamp: valid=%b data=%0d want 1/0", m_axis_tvalid, m_axis_tdata);
    end
    base_val = 0;
    step(0);
  endtask
`endif

  task automatic test_reset_midrun;
    // Leave a blocked word and a drop pending, then reset mid-pulse.
    m_axis_tready = 1'b0;
    step(100);
    step(0);
    step(150);
    step(0);
    step(200);
    checks++;
    if (m_axis_tvalid !== 1'b1 || sts_drops !== 32'd3) begin
      errors++;
      $display("FAIL midrun_setup: valid=%b drops=%0d want 1/3", m_axis_tvalid, sts_drops);
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 16'd0) begin
      errors++;
      $display("FAIL midrun_out: valid=%b data=%0d want 0/0", m_axis_tvalid, m_axis_tdata);
    end
    checks++;
    if (sts_drops !== 32'd0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_sts: drops=%0d tready=%b want 0/0", sts_drops, s_axis_tready);
    end
    m_axis_tready = 1'b1;
    s_axis_tdata  = 16'd0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    // prev must be back at 0 and state IDLE: 100 rises, 50 falls.
    step(100);
    step(50);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_bin(100)) begin
      errors++;
      $display("FAIL midrun_after: valid=%b data=%0d want 1/%0d",
               m_axis_tvalid, m_axis_tdata, exp_bin(100));
    end
    step(0);
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_window();
    test_dead_time();
    test_back_to_back();
    test_backpressure();
`ifdef AXIS_PHA_BASELINE_EN
    test_baseline();
`endif
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
